// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the data-memory request bus.
// Word-addressed RAM with byte-strobe writes, a fixed number of wait cycles
// between acceptance and response, and a one-cycle done pulse per request.
// Out-of-range requests complete with access_err_o and a zero read word.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_strb_i,
  input  logic        mem_wen_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        access_err_o,
  output logic        protocol_err_o,
  output logic        busy_o
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        wen_q;
  logic        done_q;
  logic        aerr_q;
  logic        perr_q;
  logic [31:0] rdata_q;
  logic [31:0] ram_q [DEPTH_WORDS];

  logic [31:0]   acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic [3:0]    acc_strb_s;
  logic          acc_wen_s;
  logic [32:0]   offset_s;
  logic          in_range_s;
  logic [AW-1:0] idx_s;
  logic          enter_resp_s;

  // Select the request being serviced (live inputs when the access happens on
  // the accepting edge itself), decode range/index, and flag the RESP entry edge.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr_s  = mem_addr_i;
      acc_wdata_s = mem_wdata_i;
      acc_strb_s  = mem_strb_i;
      acc_wen_s   = mem_wen_i;
    end else begin
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
      acc_strb_s  = strb_q;
      acc_wen_s   = wen_q;
    end
    offset_s   = {1'b0, acc_addr_s} - {1'b0, BASE_ADDR};
    in_range_s = ({1'b0, acc_addr_s} >= {1'b0, BASE_ADDR}) && (offset_s < SPAN);
    idx_s      = offset_s[AW+1:2];
    case (state_q)
      ST_IDLE: enter_resp_s = mem_valid_i && (LAT4 == 4'd0);
      ST_WAIT: enter_resp_s = (cnt_q == 4'd1);
      default: enter_resp_s = 1'b0;
    endcase
  end

  // Request FSM: accept in IDLE, count wait cycles, pulse done/errors in RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      aerr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      done_q <= enter_resp_s;
      aerr_q <= enter_resp_s && !in_range_s;
      perr_q <= mem_valid_i && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (mem_valid_i) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            strb_q  <= mem_strb_i;
            wen_q   <= mem_wen_i;
            if (LAT4 == 4'd0) begin
              state_q <= ST_RESP;
            end else begin
              cnt_q   <= LAT4;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Single-port RAM: byte-lane write on the RESP entry edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_resp_s && in_range_s && acc_wen_s) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_strb_s[b]) begin
          ram_q[idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Registered read word: loaded on reads, zeroed on out-of-range, held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 32'd0;
    end else if (enter_resp_s) begin
      if (!in_range_s) begin
        rdata_q <= 32'd0;
      end else if (!acc_wen_s) begin
        rdata_q <= ram_q[idx_s];
      end
    end
  end

  assign mem_rdata_o    = rdata_q;
  assign mem_done_o     = done_q;
  assign access_err_o   = aerr_q;
  assign protocol_err_o = perr_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
